// File: rtl/cdb_arbiter.sv
// Per-source result buffers feeding NUM_CDB registered broadcast ports, granted round-robin.
// Optional: define CDB_ARB_PARTIAL_FLUSH_EN for age-based partial flush (default: full flush).
module cdb_arbiter #(
    parameter int NUM_SRC   = 5,
    parameter int NUM_CDB   = 2,
    parameter int BUF_DEPTH = 2,
    parameter int ROB_IDX_W = 5,
    parameter int PAYLOAD_W = 128,
    localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*ROB_IDX_W-1:0]   src_rob_idx,
    input  logic [NUM_SRC*PAYLOAD_W-1:0]   src_payload,
    output logic [NUM_CDB-1:0]             cdb_valid,
    output logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_idx,
    output logic [NUM_CDB*PAYLOAD_W-1:0]   cdb_payload,
    output logic [NUM_CDB*SRC_W-1:0]       cdb_src,
    input  logic                           flush,
    input  logic [ROB_IDX_W-1:0]           flush_tag,
    input  logic [ROB_IDX_W-1:0]           rob_head
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [ROB_IDX_W-1:0] ent_idx_q [NUM_SRC][BUF_DEPTH];
    logic [ROB_IDX_W-1:0] ent_idx_d [NUM_SRC][BUF_DEPTH];
    logic [PAYLOAD_W-1:0] ent_pl_q  [NUM_SRC][BUF_DEPTH];
    logic [PAYLOAD_W-1:0] ent_pl_d  [NUM_SRC][BUF_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_SRC], rd_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_SRC], wr_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]     cnt_q [NUM_SRC], cnt_d [NUM_SRC];
    logic [SRC_W-1:0]     rr_q, rr_d;

    logic [NUM_CDB-1:0]           cdb_valid_q, cdb_valid_d;
    logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [NUM_CDB*PAYLOAD_W-1:0] cdb_payload_q, cdb_payload_d;
    logic [NUM_CDB*SRC_W-1:0]     cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0] head_kill, in_kill, eligible, grant, push, pop;
    logic [SRC_W-1:0]   port_src [NUM_CDB];
    logic [NUM_CDB-1:0] port_vld;
    logic               any_grant;
    logic [SRC_W-1:0]   last_src;

`ifdef CDB_ARB_PARTIAL_FLUSH_EN
    logic ent_kill_q [NUM_SRC][BUF_DEPTH];
    logic ent_kill_d [NUM_SRC][BUF_DEPTH];

    // Age is distance from the ROB head, so comparisons survive tag wrap-around.
    function automatic logic is_younger(input logic [ROB_IDX_W-1:0] idx,
                                        input logic [ROB_IDX_W-1:0] tag,
                                        input logic [ROB_IDX_W-1:0] head);
        logic [ROB_IDX_W-1:0] age_idx;
        logic [ROB_IDX_W-1:0] age_tag;
        age_idx = idx - head;
        age_tag = tag - head;
        return age_idx > age_tag;
    endfunction
`else
    logic unused_tags;
    assign unused_tags = ^{flush_tag, rob_head};
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (BUF_DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_kill = '0;
        in_kill   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef CDB_ARB_PARTIAL_FLUSH_EN
            head_kill[i] = ent_kill_q[i][rd_ptr_q[i]] |
                           (flush & is_younger(ent_idx_q[i][rd_ptr_q[i]], flush_tag, rob_head));
            in_kill[i]   = flush & is_younger(src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W], flush_tag, rob_head);
`endif
            src_ready[i] = cnt_q[i] != CNT_W'(BUF_DEPTH);
            eligible[i]  = (cnt_q[i] != '0) && !head_kill[i];
        end
    end

    // Scan from rr; the k-th eligible source lands on port k.
    always_comb begin
        int n;
        int s;
        n         = 0;
        s         = 0;
        grant     = '0;
        port_vld  = '0;
        any_grant = 1'b0;
        last_src  = '0;
        for (int p = 0; p < NUM_CDB; p++) port_src[p] = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            s = (int'(rr_q) + k) % NUM_SRC;
            if (eligible[s] && n < NUM_CDB) begin
                grant[s]    = 1'b1;
                port_vld[n] = 1'b1;
                port_src[n] = SRC_W'(s);
                last_src    = SRC_W'(s);
                any_grant   = 1'b1;
                n++;
            end
        end
    end

    always_comb begin
        ent_idx_d     = ent_idx_q;
        ent_pl_d      = ent_pl_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        rr_d          = rr_q;
        push          = '0;
        pop           = '0;
        cdb_valid_d   = port_vld;
        cdb_rob_idx_d = '0;
        cdb_payload_d = '0;
        cdb_src_d     = '0;
`ifdef CDB_ARB_PARTIAL_FLUSH_EN
        ent_kill_d    = ent_kill_q;
`endif
        for (int p = 0; p < NUM_CDB; p++) begin
            if (port_vld[p]) begin
                cdb_rob_idx_d[p*ROB_IDX_W +: ROB_IDX_W] = ent_idx_q[port_src[p]][rd_ptr_q[port_src[p]]];
                cdb_payload_d[p*PAYLOAD_W +: PAYLOAD_W] = ent_pl_q[port_src[p]][rd_ptr_q[port_src[p]]];
                cdb_src_d[p*SRC_W +: SRC_W]             = port_src[p];
            end
        end
        if (any_grant) rr_d = (last_src == SRC_W'(NUM_SRC - 1)) ? '0 : last_src + 1'b1;

        for (int i = 0; i < NUM_SRC; i++) begin
            // Killed heads drain as bubbles alongside ordinary grants.
            pop[i]  = (cnt_q[i] != '0) && (grant[i] || head_kill[i]);
            push[i] = src_valid[i] && src_ready[i] && !in_kill[i];
`ifdef CDB_ARB_PARTIAL_FLUSH_EN
            for (int j = 0; j < BUF_DEPTH; j++) begin
                if (flush && is_younger(ent_idx_q[i][j], flush_tag, rob_head)) ent_kill_d[i][j] = 1'b1;
            end
            if (push[i]) ent_kill_d[i][wr_ptr_q[i]] = 1'b0;
`endif
            if (push[i]) begin
                ent_idx_d[i][wr_ptr_q[i]] = src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                ent_pl_d[i][wr_ptr_q[i]]  = src_payload[i*PAYLOAD_W +: PAYLOAD_W];
                wr_ptr_d[i]               = ptr_inc(wr_ptr_q[i]);
            end
            if (pop[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end

`ifdef CDB_ARB_PARTIAL_FLUSH_EN
        if (flush) rr_d = rr_q;
`else
        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_d[i]    = '0;
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
            end
            cdb_valid_d = '0;
            rr_d        = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        ent_idx_q <= ent_idx_d;
        ent_pl_q  <= ent_pl_d;
`ifdef CDB_ARB_PARTIAL_FLUSH_EN
        ent_kill_q <= ent_kill_d;
`endif
        if (rst) begin
            cnt_q         <= '{default: '0};
            rd_ptr_q      <= '{default: '0};
            wr_ptr_q      <= '{default: '0};
            rr_q          <= '0;
            cdb_valid_q   <= '0;
            cdb_rob_idx_q <= '0;
            cdb_payload_q <= '0;
            cdb_src_q     <= '0;
        end else begin
            cnt_q         <= cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rr_q          <= rr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_payload_q <= cdb_payload_d;
            cdb_src_q     <= cdb_src_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_payload = cdb_payload_q;
    assign cdb_src     = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_cdb_arbiter;
    localparam int NUM_SRC   = 5;
    localparam int NUM_CDB   = 2;
    localparam int BUF_DEPTH = 2;
    localparam int ROB_IDX_W = 5;
    localparam int PAYLOAD_W = 128;
    localparam int SRC_W     = 3;
`ifdef CDB_ARB_PARTIAL_FLUSH_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_SRC-1:0]           src_valid = '0;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_idx = '0;
    logic [NUM_SRC*PAYLOAD_W-1:0] src_payload = '0;
    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob_idx;
    logic [NUM_CDB*PAYLOAD_W-1:0] cdb_payload;
    logic [NUM_CDB*SRC_W-1:0]     cdb_src;
    logic                         flush = 1'b0;
    logic [ROB_IDX_W-1:0]         flush_tag = '0;
    logic [ROB_IDX_W-1:0]         rob_head = '0;

    cdb_arbiter #(
        .NUM_SRC(NUM_SRC), .NUM_CDB(NUM_CDB), .BUF_DEPTH(BUF_DEPTH),
        .ROB_IDX_W(ROB_IDX_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rob_idx(src_rob_idx), .src_payload(src_payload),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
        .cdb_payload(cdb_payload), .cdb_src(cdb_src),
        .flush(flush), .flush_tag(flush_tag), .rob_head(rob_head)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [ROB_IDX_W-1:0] idx;
        logic [PAYLOAD_W-1:0] pl;
        bit                   killed;
    } ent_t;

    ent_t                 mq [NUM_SRC][$];
    int                   rr_m = 0;
    logic [NUM_CDB-1:0]   exp_valid = '0;
    logic [ROB_IDX_W-1:0] exp_idx [NUM_CDB];
    logic [PAYLOAD_W-1:0] exp_pl  [NUM_CDB];
    int                   exp_src [NUM_CDB];
    int                   n_cmp = 0;
    int                   n_fail = 0;

    function automatic int age(input logic [ROB_IDX_W-1:0] x, input logic [ROB_IDX_W-1:0] h);
        return ((int'(x) - int'(h)) % 32 + 32) % 32;
    endfunction

    function automatic bit doomed(input logic [ROB_IDX_W-1:0] x);
        return age(x, rob_head) > age(flush_tag, rob_head);
    endfunction

    always @(posedge clk) begin : model
        bit   acc [NUM_SRC];
        int   n;
        int   last;
        int   s;
        bit   any;
        ent_t e;
        for (int i = 0; i < NUM_SRC; i++) acc[i] = src_valid[i] && (mq[i].size() < BUF_DEPTH);
        exp_valid = '0;
        if (rst || (!PARTIAL && flush)) begin
            for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
            rr_m = 0;
        end else begin
            if (flush) begin
                for (int i = 0; i < NUM_SRC; i++)
                    for (int j = 0; j < mq[i].size(); j++)
                        if (doomed(mq[i][j].idx)) mq[i][j].killed = 1'b1;
            end
            n = 0; any = 1'b0; last = 0;
            for (int k = 0; k < NUM_SRC; k++) begin
                s = (rr_m + k) % NUM_SRC;
                if (mq[s].size() != 0) begin
                    if (mq[s][0].killed) begin
                        e = mq[s].pop_front();
                    end else if (n < NUM_CDB) begin
                        e = mq[s].pop_front();
                        exp_valid[n] = 1'b1;
                        exp_idx[n]   = e.idx;
                        exp_pl[n]    = e.pl;
                        exp_src[n]   = s;
                        n++; last = s; any = 1'b1;
                    end
                end
            end
            if (any && !flush) rr_m = (last + 1) % NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (acc[i] && !(flush && doomed(src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]))) begin
                    e.idx    = src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                    e.pl     = src_payload[i*PAYLOAD_W +: PAYLOAD_W];
                    e.killed = 1'b0;
                    mq[i].push_back(e);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [NUM_SRC-1:0] exp_rdy;
        for (int i = 0; i < NUM_SRC; i++) exp_rdy[i] = mq[i].size() < BUF_DEPTH;
        check("src_ready", 128'(src_ready), 128'(exp_rdy));
        check("cdb_valid", 128'(cdb_valid), 128'(exp_valid));
        for (int p = 0; p < NUM_CDB; p++) begin
            if (exp_valid[p]) begin
                check("cdb_rob_idx", 128'(cdb_rob_idx[p*ROB_IDX_W +: ROB_IDX_W]), 128'(exp_idx[p]));
                check("cdb_payload", cdb_payload[p*PAYLOAD_W +: PAYLOAD_W], exp_pl[p]);
                check("cdb_src", 128'(cdb_src[p*SRC_W +: SRC_W]), 128'(exp_src[p]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        src_valid = '0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic put(input int s, input logic [ROB_IDX_W-1:0] idx);
        src_valid[s] = 1'b1;
        src_rob_idx[s*ROB_IDX_W +: ROB_IDX_W] = idx;
        src_payload[s*PAYLOAD_W +: PAYLOAD_W] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic do_reset();
        idle();
        flush_tag = '0;
        rob_head  = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int  beats;
        int  bcast1;
        bit  seen_full;
        bit  acc1;
        int  pct;

        tick();
        check("reset_valid", 128'(cdb_valid), 128'(0));
        check("reset_idx", 128'(cdb_rob_idx), 128'(0));
        check("reset_src", 128'(cdb_src), 128'(0));
        check("reset_ready", 128'(src_ready), 128'(5'h1f));

        // Single beat, latency 2.
        do_reset();
        put(2, 5'd7);
        tick(); idle();
        check("lat_early", 128'(cdb_valid), 128'(0));
        tick();
        check("lat_valid", 128'(cdb_valid), 128'(2'b01));
        check("lat_src", 128'(cdb_src[2:0]), 128'(2));
        check("lat_idx", 128'(cdb_rob_idx[4:0]), 128'(7));
        tick();
        check("lat_after", 128'(cdb_valid), 128'(0));

        // All sources at once.
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) put(s, 5'(s + 8));
        tick(); idle();
        tick();
        check("rr_c1_valid", 128'(cdb_valid), 128'(2'b11));
        check("rr_c1_src", 128'(cdb_src), 128'({3'd1, 3'd0}));
        tick();
        check("rr_c2_valid", 128'(cdb_valid), 128'(2'b11));
        check("rr_c2_src", 128'(cdb_src), 128'({3'd3, 3'd2}));
        tick();
        check("rr_c3_valid", 128'(cdb_valid), 128'(2'b01));
        check("rr_c3_src", 128'(cdb_src[2:0]), 128'(4));
        put(0, 5'd1); put(4, 5'd2);
        tick(); idle();
        tick();
        check("rr_wrap_src", 128'(cdb_src), 128'({3'd4, 3'd0}));

        // Backpressure on source 1 while every other source is busy.
        do_reset();
        beats = 0; bcast1 = 0; seen_full = 1'b0;
        for (int c = 0; c < 24; c++) begin
            idle();
            if (c < 12) begin
                for (int s = 0; s < NUM_SRC; s++) if (s != 1) put(s, 5'($urandom_range(0, 31)));
                if (beats < 4) put(1, 5'(16 + beats));
            end
            acc1 = src_valid[1] && (mq[1].size() < BUF_DEPTH);
            if (!src_ready[1]) seen_full = 1'b1;
            tick();
            if (acc1) beats++;
            for (int p = 0; p < NUM_CDB; p++)
                if (cdb_valid[p] && cdb_src[p*SRC_W +: SRC_W] == 3'd1) bcast1++;
        end
        check("bp_seen_full", 128'(seen_full), 128'(1));
        check("bp_src1_beats", 128'(bcast1), 128'(4));

`ifndef CDB_ARB_PARTIAL_FLUSH_EN
        // Full flush with beats buffered and a same-cycle source beat.
        do_reset();
        put(0, 5'd3); put(1, 5'd4); put(2, 5'd5);
        tick(); idle();
        flush = 1'b1;
        put(3, 5'd6);
        tick(); idle();
        check("flush_valid", 128'(cdb_valid), 128'(0));
        check("flush_ready", 128'(src_ready), 128'(5'h1f));
        tick();
        check("flush_valid2", 128'(cdb_valid), 128'(0));
`else
        // Partial flush, no wrap.
        do_reset();
        rob_head = 5'd2;
        put(0, 5'd4); put(1, 5'd5); put(2, 5'd6); put(3, 5'd9);
        tick(); idle();
        flush = 1'b1; flush_tag = 5'd5;
        tick(); idle();
        check("pf_valid", 128'(cdb_valid), 128'(2'b11));
        check("pf_idx", 128'(cdb_rob_idx), 128'({5'd5, 5'd4}));
        tick();
        check("pf_valid2", 128'(cdb_valid), 128'(0));
        // Partial flush across tag wrap.
        do_reset();
        rob_head = 5'd30;
        put(0, 5'd31); put(1, 5'd0); put(2, 5'd1); put(3, 5'd3);
        tick(); idle();
        flush = 1'b1; flush_tag = 5'd1;
        tick(); idle();
        check("pfw_valid", 128'(cdb_valid), 128'(2'b11));
        check("pfw_idx", 128'(cdb_rob_idx), 128'({5'd0, 5'd31}));
        tick();
        check("pfw_valid2", 128'(cdb_valid), 128'(2'b01));
        check("pfw_idx2", 128'(cdb_rob_idx[4:0]), 128'(1));
        check("pfw_src2", 128'(cdb_src[2:0]), 128'(2));
        tick();
        check("pfw_valid3", 128'(cdb_valid), 128'(0));
`endif

        // Randomized traffic with occasional flush and reset.
        do_reset();
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) pct = $urandom_range(15, 95);
            idle();
            for (int s = 0; s < NUM_SRC; s++)
                if ($urandom_range(0, 99) < pct) put(s, 5'($urandom_range(0, 31)));
            flush_tag = 5'($urandom_range(0, 31));
            rob_head  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 4) flush = 1'b1;
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            tick();
        end
        idle();
        for (int c = 0; c < 12; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
